// File: rtl/input_debounce_sync.sv
`timescale 1ns/1ps
// Purpose: synchronizes a raw asynchronous 1-bit input and debounces it into a clean level on `out`.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES - 1 edges after the first edge sampling a new level.
// Backpressure: none, free-running; every sample is consumed. Optional DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt.
module input_debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b10,
        CHK_LO    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_in;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;

    // Shift chain: `in` enters only the first flop, sync_in is the last flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Next-state, stability counter and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            STABLE_LO: begin
                out_d = 1'b0;
                if (sync_in) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            CHK_HI: begin
                if (!sync_in) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    out_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                out_d = 1'b1;
                if (!sync_in) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            CHK_LO: begin
                if (sync_in) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                out_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
    end

    // State, counter, sync chain and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch_ev;
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    // A glitch is a qualification abandoned because sync_in fell back to the stable level.
    always_comb begin
        glitch_ev    = ((state_q == CHK_HI) && !sync_in) || ((state_q == CHK_LO) && sync_in);
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_ev && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    // Saturating glitch counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
`timescale 1ns/1ps
// Purpose: randomized and directed checking of input_debounce_sync against a delay-line/run-length model.
// Latency: model predicts outputs edge by edge; directed sections also check fixed latencies.
// Backpressure: not applicable.
module tb_input_debounce_sync;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_r;
    logic       out_w;
    logic       busy_w;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    always #5 clk = ~clk;

    input_debounce_sync #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_r),
        .out        (out_w),
        .busy       (busy_w)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of raw samples delays `in` by SYNC edges; a run length
    // of consecutive samples disagreeing with the accepted level decides acceptance.
    logic mq[$];
    int   run;
    logic m_out;
    int   m_gl;
    int   m_changes;
    int   dut_edges;
    logic prev_out;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq = {};
        for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
        run   = 0;
        m_out = 1'b0;
        m_gl  = 0;
    endtask

    // One clock: drive `in`, advance the model at the edge, compare just after it.
    task automatic step(input logic v);
        logic s;
        in_r = v;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            s = mq.pop_front();
            mq.push_back(v);
            if (s != m_out) begin
                run++;
                if (run == DEB) begin
                    m_out = ~m_out;
                    run   = 0;
                    m_changes++;
                end
            end else begin
                if (run > 0 && m_gl < 255) m_gl++;
                run = 0;
            end
        end
        #1;
        check("out", {15'd0, out_w}, {15'd0, m_out});
        check("busy", {15'd0, busy_w}, {15'd0, (run > 0)});
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt", {8'd0, glitch_cnt}, 16'(m_gl));
`endif
        if (out_w != prev_out) dut_edges++;
        prev_out = out_w;
    endtask

    initial begin
        int   cyc;
        int   len;
        int   e0;
        logic lvl;
        logic hold;
        logic exp_edge;

        m_changes = 0;
        dut_edges = 0;
        prev_out  = 1'b0;
        model_reset();

        // Reset held with in=1: outputs must stay cleared.
        rst  = 1'b0;
        in_r = 1'b1;
        repeat (10) step(1'b1);

        // Release away from the edge, let the chain settle low.
        rst = 1'b1;
        repeat (4) step(1'b0);

        // Clean rise: i=0 is the first edge sampling in=1.
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("rise_out", {15'd0, out_w}, {15'd0, (i >= 5)});
            check("rise_busy", {15'd0, busy_w}, {15'd0, (i >= 2 && i <= 4)});
        end

        // Clean fall.
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            check("fall_out", {15'd0, out_w}, {15'd0, (i < 5)});
        end

        // Fall with a 2-cycle high blip mid-qualification.
        repeat (8) step(1'b1);
        step(1'b0); step(1'b0);
        step(1'b1); step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        check("blip_settled_out", {15'd0, out_w}, 16'd0);

        // 3-cycle glitches, repeated to saturate the counter.
        for (int r = 0; r < 300; r++) begin
            repeat (3) step(1'b1);
            repeat (5) step(1'b0);
            check("glitch_out", {15'd0, out_w}, 16'd0);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_sat", {8'd0, glitch_cnt}, 16'd255);
`endif

        // Reset while qualifying a rise.
        repeat (3) step(1'b1);
        check("pre_rst_busy", {15'd0, busy_w}, 16'd1);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_async_out", {15'd0, out_w}, 16'd0);
        check("rst_async_busy", {15'd0, busy_w}, 16'd0);
        @(posedge clk);
        #1;
        step(1'b1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("post_rst_out", {15'd0, out_w}, {15'd0, (i >= 5)});
        end

        // Random 1..3-cycle bursts, then a steady hold.
        for (int r = 0; r < 3; r++) begin
            e0  = dut_edges;
            lvl = 1'($urandom_range(0, 1));
            cyc = 0;
            while (cyc < 1000) begin
                len = $urandom_range(1, 3);
                repeat (len) step(lvl);
                cyc += len;
                lvl = ~lvl;
            end
            check("burst_edges", 16'(dut_edges - e0), 16'd0);
            hold     = 1'($urandom_range(0, 1));
            exp_edge = (hold != m_out);
            e0       = dut_edges;
            repeat (10) step(hold);
            check("hold_edges", 16'(dut_edges - e0), {15'd0, exp_edge});
            check("hold_level", {15'd0, out_w}, {15'd0, hold});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
